// File: rtl/lut_ram_loader.sv
// LUT RAM filled at run time from a valid/ready word stream, read back with
// one-cycle registered, enable-gated timing once a complete table is present.
module lut_ram_loader #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 6,
    parameter string TYPE       = "DISTRIBUTED"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  rd_enable,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    if (TYPE != "DISTRIBUTED" && TYPE != "BLOCK" && TYPE != "REGISTERS" &&
        TYPE != "ULTRA" && TYPE != "AUTO") begin : g_bad_type
        $error("lut_ram_loader: unsupported TYPE %s", TYPE);
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] count_next;
    logic                wr_fire;

    (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_next = state;
        count_next = wr_count;
        wr_ready   = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                    count_next = '0;
                end
            end
            LOAD: begin
                wr_ready  = 1'b1;
                load_busy = 1'b1;
                if (wr_valid) begin
                    count_next = wr_count + (ADDR_WIDTH + 1)'(1);
                    if (wr_count == LAST_IDX) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                load_done = 1'b1;
                if (load_start) begin
                    state_next = LOAD;
                    count_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wr_fire = wr_valid && (state == LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_count <= '0;
        end else begin
            state    <= state_next;
            wr_count <= count_next;
        end
    end

    // Read gating uses the registered state, so a read coinciding with the
    // final write or with a reload request sees the table as it was.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_enable && (state == READY)) begin
            rd_data  <= mem[rd_address];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_count[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lut_ram_loader.sv
// Randomized self-checking bench for lut_ram_loader (DEPTH=8) against a
// table-level reference model of load sequencing and registered reads.
module tb_lut_ram_loader;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          load_busy;
    logic          load_done;
    logic [AW:0]   wr_count;
    logic          rd_enable;
    logic [AW-1:0] rd_address;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    lut_ram_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TYPE       ("DISTRIBUTED")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .wr_count   (wr_count),
        .rd_enable  (rd_enable),
        .rd_address (rd_address),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: "loading" / "table_ok" flags, count of words taken so far.
    bit            m_loading;
    bit            m_table_ok;
    int unsigned   m_cnt;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd;
    bit            m_rv;
    int unsigned   ready_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading  = 1'b0;
        m_table_ok = 1'b0;
        m_cnt      = 0;
        m_rd       = '0;
        m_rv       = 1'b0;
    endtask

    task automatic check_all();
        check("wr_ready",  32'(wr_ready),  32'(m_loading));
        check("load_busy", 32'(load_busy), 32'(m_loading));
        check("load_done", 32'(load_done), 32'(m_table_ok));
        check("wr_count",  32'(wr_count),  m_cnt);
        check("rd_valid",  32'(rd_valid),  32'(m_rv));
        check("rd_data",   32'(rd_data),   32'(m_rd));
    endtask

    // One clock cycle: apply inputs, advance model on the edge, compare after it.
    task automatic cyc(input bit ls, input bit wv, input logic [DW-1:0] wd,
                       input bit re, input logic [AW-1:0] ra);
        load_start = ls;
        wr_valid   = wv;
        wr_data    = wd;
        rd_enable  = re;
        rd_address = ra;
        @(posedge clk);
        if (m_loading) ready_cycles += (wv ? 1 : 0);
        if (m_table_ok && re) begin
            m_rd = m_mem[ra];
            m_rv = 1'b1;
        end else begin
            m_rv = 1'b0;
        end
        if (m_loading) begin
            if (wv) begin
                m_mem[m_cnt] = wd;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_loading  = 1'b0;
                    m_table_ok = 1'b1;
                end
            end
        end else if (ls) begin
            m_loading  = 1'b1;
            m_table_ok = 1'b0;
            m_cnt      = 0;
        end
        #1;
        check_all();
    endtask

    task automatic full_load(input logic [DW-1:0] base, input bit random_data);
        logic [DW-1:0] w;
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            w = random_data ? DW'($urandom) : base + DW'(i);
            cyc(1'b0, 1'b1, w, 1'b0, '0);
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b0, DW'($urandom), 1'b1, AW'(i));
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_enable  = 1'b0;
        rd_address = '0;
        ready_cycles = 0;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle: everything ignored without load_start.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, DW'($urandom), 1'b1, AW'($urandom));
        end

        // Back-to-back load, then a single read.
        ready_cycles = 0;
        full_load(16'h1000, 1'b0);
        check("accept_cycles", ready_cycles, 32'd8);
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd5);
        check("rd_addr5", 32'(rd_data), 32'h1005);
        cyc(1'b0, 1'b0, '0, 1'b0, '0);

        // Load with wr_valid toggling, then read back every address.
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cyc(1'b0, (i % 2) == 0, DW'($urandom), 1'b0, '0);
        end
        read_all();

        // Reload requested in the same cycle as a read.
        full_load(16'h1000, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 3'd2);
        check("rd_old_on_reload", 32'(rd_data), 32'h1002);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, 16'h2000 + DW'(i), i == DEPTH - 1, 3'd2);
        end
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd2);
        check("rd_new_addr2", 32'(rd_data), 32'h2002);

        // Asynchronous reset after three writes of a load.
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, DW'($urandom), 1'b0, '0);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, DW'($urandom), 1'b1, AW'($urandom));
        end
        full_load('0, 1'b1);
        read_all();

        // load_start during LOAD must not restart the count.
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(i == 4, 1'b1, 16'h3000 + DW'(i), 1'b0, '0);
        end
        check("count_after_mid_start", 32'(wr_count), 32'd8);
        read_all();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                DW'($urandom), $urandom_range(0, 1) == 1, AW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_ram_loader.md
Name: lut_ram_loader

Overview:
- Writer-side counterpart to the read-only normalization LUT: a LUT RAM filled at run time from a valid/ready word stream, then read with the same one-cycle registered, enable-gated read timing as the ROM LUT.
- Sits between the host/config data path and the normalization unit, so LUT contents can be reloaded without re-synthesis.
- FSM sequences the load; the read port is blocked until a full table is written.

Parameters:
DATA_WIDTH, 16, width of one LUT entry
ADDR_WIDTH, 6, address width; depth DEPTH = 2^ADDR_WIDTH
TYPE, "DISTRIBUTED", ram_style attribute applied to the storage array

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
load_start  input  1  single-cycle request to (re)load the whole table
wr_data  input  DATA_WIDTH  LUT entry for the next sequential address
wr_valid  input  1  wr_data valid
wr_ready  output  1  loader accepts wr_data this cycle
load_busy  output  1  high while in LOAD
load_done  output  1  high while in READY (table complete)
wr_count  output  ADDR_WIDTH+1  entries written in current load, 0..DEPTH
rd_enable  input  1  read request
rd_address  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle pulse: rd_data updated by accepted read

Behaviour:
- Reset, asynchronous, immediate: state=IDLE; wr_count=0; rd_data=0; rd_valid=0. Storage array is not reset. Derived outputs in IDLE: wr_ready=0, load_busy=0, load_done=0.
- Reset asserted mid-LOAD aborts the load; partial contents are retained but unusable until a new full load completes.
- States: IDLE, LOAD, READY.
- IDLE: load_start -> LOAD with wr_count<=0. Other inputs ignored.
- LOAD: wr_ready=1 (combinational from state only, no dependency on wr_valid); load_busy=1.
  - Handshake fires when wr_valid & wr_ready: mem[wr_count[ADDR_WIDTH-1:0]]<=wr_data; wr_count<=wr_count+1.
  - Write fired with wr_count==DEPTH-1: next state READY; wr_count becomes DEPTH and holds.
  - load_start in LOAD is ignored; no restart.
  - wr_valid low: no write, count holds.
- READY: wr_ready=0; load_done=1; wr_count holds DEPTH.
  - load_start -> LOAD with wr_count<=0; load_done drops next cycle.
  - Contents persist until overwritten entry by entry.
- Read port:
  - rd_enable=1 in READY: next edge rd_data<=mem[rd_address], rd_valid<=1. Latency 1 cycle; back-to-back reads every cycle.
  - rd_enable=0, or state not READY: rd_data holds its previous value; rd_valid<=0.
- Simultaneous events:
  - load_start with rd_enable in READY: read is serviced from old contents; state -> LOAD.
  - Final write with rd_enable: read is ignored (state is still LOAD); READY takes effect next cycle.
- Width rules: wr_count is ADDR_WIDTH+1 bits so DEPTH is representable; the write address is its low ADDR_WIDTH bits; no wrap within a load.

Test Plan (ADDR_WIDTH=3, DATA_WIDTH=16, DEPTH=8):
- Reset, then idle 5 cycles with rd_enable=1, wr_valid=1 -> wr_ready=0, load_done=0, rd_valid=0, rd_data=16'h0000 throughout.
- load_start pulse, then 8 back-to-back words 16'h1000..16'h1007 -> wr_ready high for exactly 8 accepting cycles; load_done=1 the cycle after the 8th write; wr_count=8. Read addr 5 -> rd_data=16'h1005 one cycle later with rd_valid pulse.
- Load with wr_valid toggled 1,0,1,0… -> only valid cycles write; wr_count advances only on handshakes; final contents in address order, no skipped or duplicated entries.
- In READY, same cycle: rd_enable (addr 2) and load_start -> rd_data=16'h1002 next cycle, load_busy=1. Reload with 16'h2000..16'h2007, read addr 2 -> 16'h2002.
- Reset asserted asynchronously after 3 writes of a load -> outputs clear immediately without a clock edge; state IDLE; reads blocked until a new complete load.
- load_start pulsed in LOAD after 4 writes -> ignored; wr_count continues 5..8; load completes normally.
